// File: rtl/branch_predict_resolver.sv
// rtl/branch_predict_resolver.sv - branch resolution, 2-bit BHT prediction and misprediction statistics
module branch_predict_resolver #(
  parameter int PC_W      = 9,
  parameter int BHT_DEPTH = 16,
  parameter int STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_pred_taken,
  input  logic              ALU_eq,
  input  logic              ALU_lt,
  input  logic              ALU_gt,
  input  logic [5:0]        br_ctrl,
  input  logic              jump_ctrl,
  output logic              branch,
  output logic              mispredict,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]        ctr_q [BHT_DEPTH];
  logic [1:0]        ctr_d;
  logic [1:0]        ex_ctr;
  logic              ctr_we;
  logic [STAT_W-1:0] br_count_q, br_count_d;
  logic [STAT_W-1:0] mispred_count_q, mispred_count_d;
  logic [IDX_W-1:0]  if_idx, ex_idx;
  logic              cond, is_ctrl;
  logic              unused_pc_bits;

  assign if_idx = if_pc[IDX_W-1:0];
  assign ex_idx = ex_pc[IDX_W-1:0];
  // Only the low index bits address the table; aliased PCs share an entry.
  assign unused_pc_bits = ^{if_pc, ex_pc};

  // br_ctrl bit order is {ge, le, gt, lt, eq, neq}.
  always_comb begin
    cond = (br_ctrl[1] & ALU_eq)
         | (br_ctrl[0] & ~ALU_eq)
         | (br_ctrl[2] & ALU_lt)
         | (br_ctrl[3] & ALU_gt)
         | (br_ctrl[4] & (ALU_lt | ALU_eq))
         | (br_ctrl[5] & (ALU_gt | ALU_eq));
    is_ctrl    = (|br_ctrl) | jump_ctrl;
    branch     = ex_valid & (cond | jump_ctrl);
    mispredict = ex_valid & ((is_ctrl & (branch != ex_pred_taken)) | (~is_ctrl & ex_pred_taken));
    pred_taken = if_valid & ctr_q[if_idx][1];
  end

  always_comb begin
    ex_ctr = ctr_q[ex_idx];
    ctr_we = ex_valid & is_ctrl;
    ctr_d  = ex_ctr;
    if (|br_ctrl) begin
      if (cond) begin
        ctr_d = (ex_ctr == 2'd3) ? 2'd3 : ex_ctr + 2'd1;
      end else begin
        ctr_d = (ex_ctr == 2'd0) ? 2'd0 : ex_ctr - 2'd1;
      end
    end else if (jump_ctrl) begin
      ctr_d = 2'd3;
    end
  end

  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (ex_valid && is_ctrl && (br_count_q != {STAT_W{1'b1}})) begin
      br_count_d = br_count_q + STAT_W'(1);
    end
    if (mispredict && (mispred_count_q != {STAT_W{1'b1}})) begin
      mispred_count_d = mispred_count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        ctr_q[i] <= 2'd1;
      end
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      if (ctr_we) begin
        ctr_q[ex_idx] <= ctr_d;
      end
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predict_resolver.sv
// tb/tb_branch_predict_resolver.sv - vector table, corner sequences and random checks against a reference model
module tb_branch_predict_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [8:0]  if_pc;
  logic        pred_taken, pred_taken4;
  logic        ex_valid;
  logic [8:0]  ex_pc;
  logic        ex_pred_taken;
  logic        ALU_eq, ALU_lt, ALU_gt;
  logic [5:0]  br_ctrl;
  logic        jump_ctrl;
  logic        branch, mispredict, branch4, mispredict4;
  logic [15:0] br_count, mispred_count;
  logic [3:0]  br_count4, mispred_count4;

  always #5 clk = ~clk;

  branch_predict_resolver #(.PC_W(9), .BHT_DEPTH(16), .STAT_W(16)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ALU_eq(ALU_eq), .ALU_lt(ALU_lt), .ALU_gt(ALU_gt), .br_ctrl(br_ctrl), .jump_ctrl(jump_ctrl),
    .branch(branch), .mispredict(mispredict), .br_count(br_count), .mispred_count(mispred_count)
  );

  branch_predict_resolver #(.PC_W(9), .BHT_DEPTH(16), .STAT_W(4)) dut4 (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .pred_taken(pred_taken4),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .ALU_eq(ALU_eq), .ALU_lt(ALU_lt), .ALU_gt(ALU_gt), .br_ctrl(br_ctrl), .jump_ctrl(jump_ctrl),
    .branch(branch4), .mispredict(mispredict4), .br_count(br_count4), .mispred_count(mispred_count4)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: counter values 0..3 per entry and unbounded-then-clamped statistics.
  int ctr_m [16];
  int brc_m, mpc_m;

  typedef struct {
    logic [5:0] bc;
    logic       jmp;
    logic       e, l, g;
    logic       pred;
    logic       exp_br;
    logic       exp_mp;
  } vec_t;
  vec_t tbl [19];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Comparison meaning of each br_ctrl bit, from the relation the flags describe.
  function automatic bit f_cond(input logic [5:0] bc, input logic e, input logic l, input logic g);
    bit r = 0;
    if (bc[5] && (g || e)) r = 1;
    if (bc[4] && (l || e)) r = 1;
    if (bc[3] && g)        r = 1;
    if (bc[2] && l)        r = 1;
    if (bc[1] && e)        r = 1;
    if (bc[0] && !e)       r = 1;
    return r;
  endfunction

  function automatic bit m_branch();
    return ex_valid && (f_cond(br_ctrl, ALU_eq, ALU_lt, ALU_gt) || jump_ctrl);
  endfunction

  function automatic bit m_misp();
    bit isc = (br_ctrl != 0) || jump_ctrl;
    if (!ex_valid) return 0;
    return isc ? (m_branch() != ex_pred_taken) : ex_pred_taken;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ctr_m[i] = 1;
    brc_m = 0;
    mpc_m = 0;
  endtask

  task automatic set_ex(input logic v, input int pc, input logic pred, input logic [5:0] bc,
                        input logic jmp, input logic e, input logic l, input logic g);
    ex_valid = v; ex_pc = 9'(pc); ex_pred_taken = pred; br_ctrl = bc; jump_ctrl = jmp;
    ALU_eq = e; ALU_lt = l; ALU_gt = g;
  endtask

  task automatic set_if(input logic v, input int pc);
    if_valid = v; if_pc = 9'(pc);
  endtask

  task automatic at_neg();
    @(negedge clk);
    chk("pred_taken", int'(pred_taken), (if_valid && ctr_m[if_pc % 16] >= 2) ? 1 : 0);
    chk("branch", int'(branch), int'(m_branch()));
    chk("mispredict", int'(mispredict), int'(m_misp()));
    chk("br_count", int'(br_count), clamp(brc_m, 0, 65535));
    chk("mispred_count", int'(mispred_count), clamp(mpc_m, 0, 65535));
    chk("br_count4", int'(br_count4), clamp(brc_m, 0, 15));
    chk("mispred_count4", int'(mispred_count4), clamp(mpc_m, 0, 15));
  endtask

  task automatic advance();
    int idx;
    bit c;
    @(posedge clk);
    idx = ex_pc % 16;
    c   = f_cond(br_ctrl, ALU_eq, ALU_lt, ALU_gt);
    if (reset) begin
      model_reset();
    end else begin
      if (ex_valid && br_ctrl != 0) ctr_m[idx] = clamp(ctr_m[idx] + (c ? 1 : -1), 0, 3);
      else if (ex_valid && jump_ctrl) ctr_m[idx] = 3;
      if (ex_valid && (br_ctrl != 0 || jump_ctrl)) brc_m++;
      if (m_misp()) mpc_m++;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_if(0, 0);
    set_ex(0, 0, 0, 6'b0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;

    // Every entry starts weak not-taken; counts start at zero.
    for (int i = 0; i < 16; i++) begin
      set_if(1, i);
      at_neg();
      chk("reset_pred", int'(pred_taken), 0);
      advance();
    end
    chk("reset_brc", int'(br_count), 0);
    chk("reset_mpc", int'(mispred_count), 0);

    // Repeated taken beq at pc 5 with a stale not-taken prediction.
    set_if(1, 5);
    for (int i = 0; i < 3; i++) begin
      set_ex(1, 5, 0, 6'b000010, 0, 1, 0, 0);
      at_neg();
      chk("beq_branch", int'(branch), 1);
      chk("beq_pred", int'(pred_taken), (i == 0) ? 0 : 1);
      advance();
    end
    set_ex(0, 0, 0, 6'b0, 0, 0, 0, 0);
    at_neg();
    chk("beq_brc", int'(br_count), 3);
    chk("beq_mpc", int'(mispred_count), 3);
    set_ex(1, 5, 1, 6'b000010, 0, 0, 0, 1);
    advance();
    set_ex(0, 0, 0, 6'b0, 0, 0, 0, 0);
    at_neg();
    chk("beq_sat_pred", int'(pred_taken), 1);
    advance();

    tbl[0]  = '{6'b100000, 0, 0, 0, 1, 0, 1, 1};
    tbl[1]  = '{6'b001000, 0, 0, 0, 1, 0, 1, 1};
    tbl[2]  = '{6'b000001, 0, 0, 0, 1, 0, 1, 1};
    tbl[3]  = '{6'b010000, 0, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{6'b000100, 0, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{6'b000010, 0, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{6'b010000, 0, 1, 0, 0, 0, 1, 1};
    tbl[7]  = '{6'b100000, 0, 1, 0, 0, 0, 1, 1};
    tbl[8]  = '{6'b000010, 0, 1, 0, 0, 0, 1, 1};
    tbl[9]  = '{6'b000001, 0, 1, 0, 0, 0, 0, 0};
    tbl[10] = '{6'b000100, 0, 1, 0, 0, 0, 0, 0};
    tbl[11] = '{6'b000100, 0, 0, 1, 0, 1, 1, 0};
    tbl[12] = '{6'b010000, 0, 0, 1, 0, 1, 1, 0};
    tbl[13] = '{6'b001000, 0, 0, 1, 0, 1, 0, 1};
    tbl[14] = '{6'b000110, 0, 0, 0, 1, 0, 0, 0};
    tbl[15] = '{6'b000000, 1, 0, 1, 0, 0, 1, 1};
    tbl[16] = '{6'b000000, 0, 0, 0, 1, 1, 0, 1};
    tbl[17] = '{6'b000000, 0, 0, 0, 1, 0, 0, 0};
    tbl[18] = '{6'b100100, 0, 0, 1, 0, 1, 1, 0};
    set_if(0, 0);
    for (int i = 0; i < 19; i++) begin
      set_ex(1, 9, tbl[i].pred, tbl[i].bc, tbl[i].jmp, tbl[i].e, tbl[i].l, tbl[i].g);
      at_neg();
      chk($sformatf("tbl%0d_branch", i), int'(branch), int'(tbl[i].exp_br));
      chk($sformatf("tbl%0d_misp", i), int'(mispredict), int'(tbl[i].exp_mp));
      advance();
    end

    // Jump at pc 20 lands in entry 4.
    set_if(1, 4);
    set_ex(1, 20, 1, 6'b0, 1, 0, 0, 0);
    at_neg();
    chk("alias_pre", int'(pred_taken), 0);
    advance();
    set_ex(0, 0, 0, 6'b0, 0, 0, 0, 0);
    at_neg();
    chk("alias_post", int'(pred_taken), 1);
    advance();

    // Same-cycle read and write of entry 7.
    set_if(1, 7);
    set_ex(1, 7, 0, 6'b000010, 0, 1, 0, 0);
    at_neg();
    chk("rw_same_cycle", int'(pred_taken), 0);
    advance();
    set_ex(0, 0, 0, 6'b0, 0, 0, 0, 0);
    at_neg();
    chk("rw_next_cycle", int'(pred_taken), 1);

    // Reset wins over a simultaneous jump update.
    reset = 1'b1;
    set_if(1, 4);
    set_ex(1, 4, 0, 6'b0, 1, 0, 0, 0);
    advance();
    reset = 1'b0;
    set_ex(0, 0, 0, 6'b0, 0, 0, 0, 0);
    at_neg();
    chk("midrst_pred", int'(pred_taken), 0);
    chk("midrst_brc", int'(br_count), 0);
    chk("midrst_mpc", int'(mispred_count), 0);
    advance();

    // Statistics saturation on the narrow instance.
    for (int i = 0; i < 20; i++) begin
      set_ex(1, i, 1, 6'b0, 1, 0, 0, 0);
      at_neg();
      advance();
    end
    for (int i = 0; i < 20; i++) begin
      set_ex(1, i, 1, 6'b0, 0, 0, 0, 0);
      at_neg();
      advance();
    end
    set_ex(0, 0, 0, 6'b0, 0, 0, 0, 0);
    at_neg();
    chk("sat4_brc", int'(br_count4), 15);
    chk("sat4_mpc", int'(mispred_count4), 15);
    chk("wide_brc", int'(br_count), 20);
    chk("wide_mpc", int'(mispred_count), 20);
    advance();

    for (int n = 0; n < 2000; n++) begin
      int rel;
      logic e, l, g;
      logic [5:0] bc;
      rel = $urandom_range(0, 7);
      if (rel == 7) begin
        e = 1'($urandom); l = 1'($urandom); g = 1'($urandom);
      end else begin
        e = (rel % 3 == 0); l = (rel % 3 == 1); g = (rel % 3 == 2);
      end
      case ($urandom_range(0, 3))
        0:       bc = 6'b0;
        1:       bc = 6'($urandom);
        default: bc = 6'(1 << $urandom_range(0, 5));
      endcase
      set_ex(1'($urandom_range(0, 3) != 0), $urandom_range(0, 511), 1'($urandom), bc,
             1'($urandom_range(0, 7) == 0), e, l, g);
      set_if(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1) ? int'(ex_pc) : $urandom_range(0, 511));
      reset = ($urandom_range(0, 127) == 0);
      at_neg();
      advance();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
